nibble_serial_adder: RTL

//   Multi-cycle WIDTH-bit adder that drives the existing 4-bit ripple adder (top_adder).
//   It feeds one nibble slice per clock and registers the carry between slices.
//   It collects the returned sum nibbles into a result word.

---
 rtl/adder_pkg.sv | 10 +
 rtl/top_adder.sv | 21 ++
 rtl/nibble_serial_adder.sv | 107 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM encodings.
package adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/top_adder.sv
// 4-bit combinational ripple-carry adder used as the serial datapath slice.
module top_adder
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single top_adder,
// carry registered between slices, valid/ready on both sides.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  state_t                state, state_nx;
  logic [WIDTH-1:0]      a_reg, b_reg, result;
  logic                  carry;
  logic [IDXW-1:0]       idx;
  logic [NIBBLE_W-1:0]   nib_a, nib_b, nib_s;
  logic                  nib_c;

  // Explicit per-nibble mux keeps the index compare width-exact for any WIDTH.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDXW'(i)) begin
        nib_a = a_reg[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_reg[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  top_adder u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_s),
    .cout (nib_c)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN:  if (idx == LAST) state_nx = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (in_valid) begin
          a_reg  <= op_a;
          b_reg  <= op_b;
          carry  <= cin;
          idx    <= '0;
          result <= '0;
        end
        ST_RUN: begin
          carry <= nib_c;
          idx   <= idx + 1'b1;
          for (int i = 0; i < NIBBLES; i++)
            if (idx == IDXW'(i)) result[i*NIBBLE_W +: NIBBLE_W] <= nib_s;
        end
        default: ;
      endcase
    end
  end

  // Partial sums never leak: the word is only driven while the result is valid.
  assign sum  = out_valid ? result : '0;
  assign cout = out_valid & carry;
endmodule
